dut_scan_sequencer: RTL

- Sequences the part-under-test scan interface: generates the part clock, scan enable, test mode and part reset.
- Serialises bits in and out of the scan chain on command from the serial command parser.
- Replaces ad-hoc clock toggling in the parser with one owner of part clock/test pins; the parser only issues commands and moves bit streams.

---
 rtl/dut_scan_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dut_scan_sequencer.sv
`timescale 1ns/1ps
// dut_scan_sequencer
// Single owner of the part-under-test scan pins. Takes SHIFT / EXEC / PRST
// commands from the serial command parser, generates the part clock, scan
// enable, test mode and part reset, and moves scan bits in and out over
// valid/ready bit streams.
//
// Optional build macro: SCAN_ABORT_EN adds i_abort. When it is high in any
// busy state the command is cut short: part clock low, part reset released,
// pending scan-out bit dropped, and the command finishes with a done pulse.
//
// Ports
//   clk, rstn                    system clock, async active-low reset
//   i_cmd_valid/o_cmd_ready      command handshake (ready only in IDLE)
//   i_cmd_op[1:0]                0=SHIFT 1=EXEC 2=PRST 3=NOP
//   i_cmd_len[LEN_W-1:0]         bit count / clock count / reset cycles
//   i_sin_valid/o_sin_ready      shift-in stream, i_sin_bit is the payload
//   o_sout_valid/i_sout_ready    shift-out stream, o_sout_bit is the payload
//   o_busy, o_done               activity flag, one-cycle completion pulse
//   o_part_clk/rstn/se/tm        part clock, reset, scan enable, test mode
//   o_part_scan_i, i_part_scan_o scan chain input / output
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// SH_GET   | waiting for a shift-in bit; captures scan_o as it arrives
// SH_PUT   | offering the captured scan_o bit downstream
// CLK_LO   | shift clock low phase
// CLK_HI   | shift clock high phase, bit counted on exit
// EX_LO    | exec clock low phase
// EX_HI    | exec clock high phase, pulse counted on exit
// RST_HOLD | part reset asserted
// FIN      | restore scan pins, pulse done
module dut_scan_sequencer #(
  parameter int HALF_PER = 2,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef SCAN_ABORT_EN
  input  logic             i_abort,
`endif
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_sin_valid,
  output logic             o_sin_ready,
  input  logic             i_sin_bit,
  output logic             o_sout_valid,
  input  logic             i_sout_ready,
  output logic             o_sout_bit,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_part_clk,
  output logic             o_part_rstn,
  output logic             o_part_se,
  output logic             o_part_tm,
  output logic             o_part_scan_i,
  input  logic             i_part_scan_o
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SH_GET   = 4'd1;
  localparam logic [3:0] S_SH_PUT   = 4'd2;
  localparam logic [3:0] S_CLK_LO   = 4'd3;
  localparam logic [3:0] S_CLK_HI   = 4'd4;
  localparam logic [3:0] S_EX_LO    = 4'd5;
  localparam logic [3:0] S_EX_HI    = 4'd6;
  localparam logic [3:0] S_RST_HOLD = 4'd7;
  localparam logic [3:0] S_FIN      = 4'd8;

  localparam logic [1:0] OP_SHIFT = 2'd0;
  localparam logic [1:0] OP_EXEC  = 2'd1;
  localparam logic [1:0] OP_NOP   = 2'd3;

  localparam int             PH_W    = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [PH_W-1:0] PH_LOAD = PH_W'(HALF_PER - 1);

  logic [3:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [PH_W-1:0]  r_ph;
  logic             r_scan_o_q;
  logic             w_last;
  logic             w_abort;

  // cnt only advances while below len, so the +1 never wraps
  assign w_last = ((r_cnt + LEN_W'(1)) == r_len);

`ifdef SCAN_ABORT_EN
  assign w_abort = i_abort && (r_state != S_IDLE) && (r_state != S_FIN);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scan_o_q <= 1'b0;
    end else begin
      r_scan_o_q <= i_part_scan_o;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_cnt         <= '0;
      r_ph          <= '0;
      o_cmd_ready   <= 1'b0;
      o_sin_ready   <= 1'b0;
      o_sout_valid  <= 1'b0;
      o_sout_bit    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_part_clk    <= 1'b0;
      o_part_rstn   <= 1'b1;
      o_part_se     <= 1'b1;
      o_part_tm     <= 1'b1;
      o_part_scan_i <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (w_abort) begin
        o_part_clk   <= 1'b0;
        o_part_rstn  <= 1'b1;
        o_sout_valid <= 1'b0;
        o_sin_ready  <= 1'b0;
        r_state      <= S_FIN;
      end else begin
        case (r_state)
          S_IDLE: begin
            o_cmd_ready <= 1'b1;
            if (i_cmd_valid && o_cmd_ready) begin
              o_cmd_ready <= 1'b0;
              o_busy      <= 1'b1;
              r_len       <= i_cmd_len;
              r_cnt       <= '0;
              if ((i_cmd_len == '0) || (i_cmd_op == OP_NOP)) begin
                r_state <= S_FIN;
              end else begin
                case (i_cmd_op)
                  OP_SHIFT: begin
                    o_part_se   <= 1'b1;
                    o_part_tm   <= 1'b1;
                    o_sin_ready <= 1'b1;
                    r_state     <= S_SH_GET;
                  end
                  OP_EXEC: begin
                    o_part_se <= 1'b0;
                    o_part_tm <= 1'b0;
                    r_ph      <= PH_LOAD;
                    r_state   <= S_EX_LO;
                  end
                  default: begin
                    o_part_rstn <= 1'b0;
                    r_state     <= S_RST_HOLD;
                  end
                endcase
              end
            end
          end
          S_SH_GET: begin
            // scan_o is captured before the edge that shifts this bit in
            if (i_sin_valid) begin
              o_sin_ready   <= 1'b0;
              o_part_scan_i <= i_sin_bit;
              o_sout_bit    <= r_scan_o_q;
              o_sout_valid  <= 1'b1;
              r_state       <= S_SH_PUT;
            end
          end
          S_SH_PUT: begin
            if (i_sout_ready) begin
              o_sout_valid <= 1'b0;
              r_ph         <= PH_LOAD;
              r_state      <= S_CLK_LO;
            end
          end
          S_CLK_LO, S_EX_LO: begin
            if (r_ph == '0) begin
              o_part_clk <= 1'b1;
              r_ph       <= PH_LOAD;
              r_state    <= (r_state == S_CLK_LO) ? S_CLK_HI : S_EX_HI;
            end else begin
              r_ph <= r_ph - PH_W'(1);
            end
          end
          S_CLK_HI, S_EX_HI: begin
            if (r_ph == '0) begin
              o_part_clk <= 1'b0;
              r_cnt      <= r_cnt + LEN_W'(1);
              if (w_last) begin
                r_state <= S_FIN;
              end else if (r_state == S_CLK_HI) begin
                o_sin_ready <= 1'b1;
                r_state     <= S_SH_GET;
              end else begin
                r_ph    <= PH_LOAD;
                r_state <= S_EX_LO;
              end
            end else begin
              r_ph <= r_ph - PH_W'(1);
            end
          end
          S_RST_HOLD: begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_last) begin
              o_part_rstn <= 1'b1;
              r_state     <= S_FIN;
            end
          end
          S_FIN: begin
            o_done      <= 1'b1;
            o_part_se   <= 1'b1;
            o_part_tm   <= 1'b1;
            o_busy      <= 1'b0;
            o_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
